booth_mul: RTL and testbench
============================

# booth_mul

Sequential signed radix-2 Booth multiplier for the arithmetic unit, the inverse operation of the team's restoring divider. It accepts two WIDTH-bit two's-complement operands on a start pulse and iterates one Booth step per clock. It returns a 2·WIDTH-bit product with a one-cycle done pulse, using the same start/done handshake as the divider, so the two blocks are interchangeable behind the arithmetic unit's sequencer.

## Interface
- WIDTH, 8, operand width in bits; product is 2·WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; operands sampled on the same edge
- inbus1  input  WIDTH  multiplicand M, signed
- inbus2  input  WIDTH  multiplier Q, signed
- prod_hi  output  WIDTH  upper half of product
- prod_lo  output  WIDTH  lower half of product
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when the product becomes valid
- ovf  output  1  present only with BOOTH_MUL_OVF_EN; see Configuration

## Operation
- State registers:
  - A: WIDTH+1 bits, sign-extended. The extra bit makes −M correct for M = −2^(WIDTH−1).
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - count: iteration counter.
  - busy, busy_d.
- Two states:
  - IDLE (busy=0).
  - RUN (busy=1).
- IDLE → RUN when start=1:
  - A←0, Q←inbus2, q_m1←0, M←sext(inbus1), count←0.
- Each RUN cycle, Booth pair {Q[0], q_m1}:
  - 00/11: A unchanged.
  - 01: A←A+M.
  - 10: A←A+~M+1, i.e. subtract via adder cin=1.
  - Then arithmetic right shift of {A, Q, q_m1} by one; A's MSB is replicated.
  - count increments.
- RUN → IDLE on the cycle count = WIDTH−1 completes, i.e. after exactly WIDTH iterations.
- Result mapping: prod_hi = A[WIDTH−1:0], prod_lo = Q.
  - Held stable in IDLE until the next accepted start.
- start while busy=1: ignored; the operation in progress continues unaffected.
- start in the same cycle done=1: accepted normally.
- Arithmetic is modulo 2^(WIDTH+1) in A.
  - The full signed product always fits in 2·WIDTH bits, including (−2^(WIDTH−1))².
- Reset mid-operation:
  - All registers return to reset values immediately.
  - No done pulse follows.
- Reset values: prod_hi=0, prod_lo=0, busy=0, done=0, ovf=0, count=0.

## Timing
- start sampled at edge E0; iterations occur at edges E1..E_WIDTH.
- busy is high from after E0 to after E_WIDTH, i.e. WIDTH cycles.
- prod_hi/prod_lo are valid from after E_WIDTH.
- done = !busy & busy_d:
  - High for exactly one cycle, between E_WIDTH and E_WIDTH+1.
- Throughput: one product every WIDTH+1 cycles when start is issued on the done cycle.
- No combinational path from inputs to outputs; all outputs are registered, or derived from registered busy/busy_d.

## Configuration
- Macro: BOOTH_MUL_OVF_EN.
- Defined:
  - Adds output ovf, registered and updated at the final iteration.
  - ovf=1 when the product does not fit in WIDTH signed bits, i.e. prod_hi ≠ {WIDTH{prod_lo[WIDTH−1]}}.
  - ovf is cleared on accepted start and on reset.
- Undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package booth_mul_pkg holds:
  - Default WIDTH.
  - Counter width = $clog2(WIDTH).
  - Booth pair encodings: BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11.
- One sub-module: the team's parallel_adder at WIDTH+1 bits.
  - A=A register.
  - B = M or ~M, selected by the Booth pair.
  - cin=1 for subtract; cout unused.
  - Only one adder is instantiated.

## Test plan
- Unsigned-range case: inbus1=3, inbus2=5, start → after 8 busy cycles {prod_hi,prod_lo}=16'h000F, done pulses one cycle, ovf=0.
- Mixed sign: inbus1=−7 (8'hF9), inbus2=6 → 16'hFFD6 (−42); with OVF_EN, ovf=0.
- Extreme: inbus1=8'h80, inbus2=8'h80 → 16'h4000; ovf=1.
- Large positive: inbus1=8'h7F, inbus2=8'h7F → 16'h3F01, ovf=1. Then start on the done cycle with 0×8'h55 → 16'h0000 exactly 9 cycles later.
- Start while busy: start 5×−1, re-pulse start with 2×2 at iteration 3 → second start ignored; result 16'hFFFB, single done.
- Reset mid-run: assert rst low at iteration 4 → busy, done, prod_hi, prod_lo all 0 immediately; no done after release; next start runs normally.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared constants and types for the booth_mul multiplier
//
// Contents:
//   DEFAULT_WIDTH   default operand width
//   COUNT_W         iteration counter width for DEFAULT_WIDTH
//   count_width()   iteration counter width for any operand width
//   booth_pair_e    encodings of the Booth pair {Q[0], q_m1}
//   state_e         sequencer states
package booth_mul_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int COUNT_W       = $clog2(DEFAULT_WIDTH);

   // A 1-bit operand would give $clog2() == 0; keep the counter at least 1 bit.
   function automatic int count_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   typedef enum logic [1:0] {
      BOOTH_NOP0 = 2'b00,
      BOOTH_ADD  = 2'b01,
      BOOTH_SUB  = 2'b10,
      BOOTH_NOP1 = 2'b11
   } booth_pair_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/booth_mul_if.sv
// rtl/booth_mul_if.sv - start/done handshake bundle between sequencer and booth_mul
//
// Signals (WIDTH-bit operands, 2*WIDTH-bit product split in halves):
//   start    one-cycle request, operands sampled on the same edge
//   inbus1   multiplicand M, signed
//   inbus2   multiplier Q, signed
//   prod_hi  upper half of product
//   prod_lo  lower half of product
//   busy     high while iterating
//   done     one-cycle pulse when the product becomes valid
//   ovf      product exceeds WIDTH signed bits (only with BOOTH_MUL_OVF_EN)
// Modports: master = sequencer side, slave = multiplier side.
interface booth_mul_if
   import booth_mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] inbus1;
   logic [WIDTH-1:0] inbus2;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;
   logic             busy;
   logic             done;
`ifdef BOOTH_MUL_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, inbus1, inbus2,
      input  prod_hi, prod_lo, busy, done
`ifdef BOOTH_MUL_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, inbus1, inbus2,
      output prod_hi, prod_lo, busy, done
`ifdef BOOTH_MUL_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/parallel_adder.sv
// rtl/parallel_adder.sv - N-bit ripple-free parallel adder with carry in/out
//
// Ports:
//   a, b   N-bit addends
//   cin    carry in
//   sum    N-bit sum
//   cout   carry out
module parallel_adder #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   assign sum  = full[N-1:0];
   assign cout = full[N];

endmodule

// File: rtl/booth_mul.sv
// rtl/booth_mul.sv - sequential signed radix-2 Booth multiplier, one step per clock
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   booth_mul_if.slave: start/inbus1/inbus2 in, prod_hi/prod_lo/busy/done out
// Optional feature: BOOTH_MUL_OVF_EN adds the registered ovf output.
module booth_mul
   import booth_mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   booth_mul_if.slave  bus
);

   localparam int            CW         = count_width(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   state_e           state;
   state_e           state_nxt;

   // A and M carry one extra sign bit so that negating M = -2^(WIDTH-1) is exact.
   logic [WIDTH:0]   a_reg;
   logic [WIDTH:0]   m_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_m1;
   logic [CW-1:0]    count;
   logic             busy_d;

   logic             busy;
   logic             accept;
   logic             last_iter;

   booth_pair_e      pair;
   logic [WIDTH:0]   add_b;
   logic             add_cin;
   logic [WIDTH:0]   add_sum;
   logic             add_cout_unused;
   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;

   // ---------------------------------------------------------------
   // Sequencer: state register / next state / outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_RUN;
         ST_RUN:  if (count == LAST_COUNT) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // start is only looked at in IDLE, so a request during RUN is dropped.
   always_comb begin
      busy      = (state == ST_RUN);
      accept    = (state == ST_IDLE) && bus.start;
      last_iter = (state == ST_RUN) && (count == LAST_COUNT);
   end

   // ---------------------------------------------------------------
   // Booth step: one shared adder does both A+M and A-M
   // ---------------------------------------------------------------
   assign pair = booth_pair_e'({q_reg[0], q_m1});

   always_comb begin
      add_b   = m_reg;
      add_cin = 1'b0;
      a_step  = a_reg;
      unique case (pair)
         BOOTH_ADD: begin
            a_step = add_sum;
         end
         BOOTH_SUB: begin
            add_b   = ~m_reg;
            add_cin = 1'b1;
            a_step  = add_sum;
         end
         BOOTH_NOP0, BOOTH_NOP1: begin
            a_step = a_reg;
         end
         default: begin
            a_step = a_reg;
         end
      endcase
   end

   parallel_adder #(
      .N (WIDTH + 1)
   ) u_adder (
      .a    (a_reg),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout_unused)
   );

   // Arithmetic right shift of {A, Q, q_m1}; the bit leaving Q becomes q_m1.
   assign a_next = {a_step[WIDTH], a_step[WIDTH:1]};
   assign q_next = {a_step[0], q_reg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg <= '0;
         q_reg <= '0;
         q_m1  <= 1'b0;
         m_reg <= '0;
         count <= '0;
      end else if (accept) begin
         a_reg <= '0;
         q_reg <= bus.inbus2;
         q_m1  <= 1'b0;
         m_reg <= {bus.inbus1[WIDTH-1], bus.inbus1};
         count <= '0;
      end else if (busy) begin
         a_reg <= a_next;
         q_reg <= q_next;
         q_m1  <= q_reg[0];
         count <= count + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_d <= 1'b0;
      end else begin
         busy_d <= busy;
      end
   end

`ifdef BOOTH_MUL_OVF_EN
   // Judged on the values the final shift is about to write, so ovf lands
   // on the same edge as the product.
   logic ovf_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_reg <= 1'b0;
      end else if (accept) begin
         ovf_reg <= 1'b0;
      end else if (last_iter) begin
         ovf_reg <= (a_next[WIDTH-1:0] != {WIDTH{q_next[WIDTH-1]}});
      end
   end

   assign bus.ovf = ovf_reg;
`endif

   // ---------------------------------------------------------------
   // Outputs: registers, or gates on registered busy/busy_d only
   // ---------------------------------------------------------------
   assign bus.prod_hi = a_reg[WIDTH-1:0];
   assign bus.prod_lo = q_reg;
   assign bus.busy    = busy;
   assign bus.done    = !busy && busy_d;

endmodule

// File: tb/tb_booth_mul.sv
// tb/tb_booth_mul.sv - self-checking bench for booth_mul against an arithmetic reference
module tb_booth_mul;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   booth_mul_if #(.WIDTH(W)) bus ();

   booth_mul #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: plain signed integer multiply.
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
      int p;
      p = int'($signed(m)) * int'($signed(q));
      return (2*W)'(p);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] m, input logic [W-1:0] q);
      int p;
      p = int'($signed(m)) * int'($signed(q));
      return (p > 127) || (p < -128);
   endfunction

   // Called at a negedge: drive a request, then follow it to done.
   task automatic do_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q);
      int cyc;
      int busy_cyc;
      bus.inbus1 = m;
      bus.inbus2 = q;
      bus.start  = 1'b1;
      cyc = 0;
      busy_cyc = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         cyc++;
         if (bus.busy) busy_cyc++;
      end while (!bus.done && cyc < 40);
      check({tag, " latency"}, cyc, 9);
      check({tag, " busy_cycles"}, busy_cyc, 8);
      check({tag, " product"}, {bus.prod_hi, bus.prod_lo}, ref_prod(m, q));
`ifdef BOOTH_MUL_OVF_EN
      check({tag, " ovf"}, bus.ovf, ref_ovf(m, q));
`endif
   endtask

   // One idle cycle after a done: pulse must be gone, product held.
   task automatic idle_gap(input string tag, input logic [2*W-1:0] exp_prod);
      @(negedge clk);
      check({tag, " done_width"}, bus.done, 1'b0);
      check({tag, " held"}, {bus.prod_hi, bus.prod_lo}, exp_prod);
   endtask

   initial begin
      int cyc;
      int dones;
      int first_done;
      logic [2*W-1:0] first_prod;
      logic [W-1:0] rm;
      logic [W-1:0] rq;

      bus.start  = 1'b0;
      bus.inbus1 = '0;
      bus.inbus2 = '0;

      repeat (2) @(negedge clk);
      check("reset busy", bus.busy, 1'b0);
      check("reset done", bus.done, 1'b0);
      check("reset prod", {bus.prod_hi, bus.prod_lo}, 16'h0000);
`ifdef BOOTH_MUL_OVF_EN
      check("reset ovf", bus.ovf, 1'b0);
`endif
      rst = 1'b1;

      @(negedge clk);
      do_op("3x5", 8'd3, 8'd5);
      check("3x5 literal", {bus.prod_hi, bus.prod_lo}, 16'h000F);
      idle_gap("3x5", 16'h000F);

      do_op("-7x6", 8'hF9, 8'd6);
      check("-7x6 literal", {bus.prod_hi, bus.prod_lo}, 16'hFFD6);
      idle_gap("-7x6", 16'hFFD6);

      do_op("80x80", 8'h80, 8'h80);
      check("80x80 literal", {bus.prod_hi, bus.prod_lo}, 16'h4000);
      idle_gap("80x80", 16'h4000);

      do_op("7Fx7F", 8'h7F, 8'h7F);
      check("7Fx7F literal", {bus.prod_hi, bus.prod_lo}, 16'h3F01);
      // start issued on the done cycle itself
      do_op("b2b 0x55", 8'h00, 8'h55);
      check("b2b literal", {bus.prod_hi, bus.prod_lo}, 16'h0000);
      idle_gap("b2b", 16'h0000);

      // start while busy: re-pulse with 2x2 at iteration 3
      bus.inbus1 = 8'd5;
      bus.inbus2 = 8'hFF;
      bus.start  = 1'b1;
      cyc = 0;
      dones = 0;
      first_done = 0;
      first_prod = '0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 3) begin
            bus.start  = 1'b1;
            bus.inbus1 = 8'd2;
            bus.inbus2 = 8'd2;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            dones++;
            if (dones == 1) begin
               first_done = cyc;
               first_prod = {bus.prod_hi, bus.prod_lo};
            end
         end
      end
      check("busy_start dones", dones, 1);
      check("busy_start latency", first_done, 9);
      check("busy_start product", first_prod, 16'hFFFB);

      // reset in the middle of a run
      @(negedge clk);
      bus.inbus1 = 8'h33;
      bus.inbus2 = 8'h44;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset busy", bus.busy, 1'b1);
      rst = 1'b0;
      #1;
      check("mid_reset busy", bus.busy, 1'b0);
      check("mid_reset done", bus.done, 1'b0);
      check("mid_reset prod", {bus.prod_hi, bus.prod_lo}, 16'h0000);
`ifdef BOOTH_MUL_OVF_EN
      check("mid_reset ovf", bus.ovf, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("post_reset no_done", dones, 0);
      do_op("post_reset", 8'h12, 8'hFD);
      idle_gap("post_reset", ref_prod(8'h12, 8'hFD));

      // random operands against the arithmetic reference
      for (int i = 0; i < 24; i++) begin
         rm = W'($urandom);
         rq = W'($urandom);
         do_op($sformatf("rand%0d %02h*%02h", i, rm, rq), rm, rq);
         if ($urandom_range(0, 1) == 1) begin
            idle_gap($sformatf("rand%0d", i), ref_prod(rm, rq));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
